// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and IF/ID pipeline register for the rv64 fetch stage.
// Boot, back-pressure stall, redirect flush and halt sequencing.
module fetch_ctrl #(
    parameter int unsigned    WIDTH    = 64,
    parameter int unsigned    INSTR    = 32,
    parameter int unsigned    COMMIT   = 161,
    parameter logic [WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WIDTH-1:0]  fetch_pc,
    input  logic [INSTR-1:0]  fetch_instr,
    input  logic [WIDTH-1:0]  fetch_pre_pc,
    input  logic [COMMIT-1:0] fetch_commit_info,
    input  logic              redirect_valid,
    input  logic [WIDTH-1:0]  redirect_pc,
    input  logic              halt,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [WIDTH-1:0]  id_pc,
    output logic [INSTR-1:0]  id_instr,
    output logic [WIDTH-1:0]  id_pre_pc,
    output logic [COMMIT-1:0] id_commit_info,
    output logic [1:0]        ctrl_state,
    output logic [WIDTH-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic              id_valid_q, id_valid_d;
    logic [WIDTH-1:0]  id_pc_q, id_pc_d;
    logic [INSTR-1:0]  id_instr_q, id_instr_d;
    logic [WIDTH-1:0]  id_pre_pc_q, id_pre_pc_d;
    logic [COMMIT-1:0] id_ci_q, id_ci_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              load;

    // The slot is free when empty or draining this cycle; a redirect
    // always wins over a load.
    assign load = (!id_valid_q || id_ready) && !redirect_valid;

    // Next-state and datapath selection; everything holds by default.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;
        id_pre_pc_d = id_pre_pc_q;
        id_ci_d     = id_ci_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    // Flush the entry; targets are word aligned.
                    pc_d       = {redirect_pc[WIDTH-1:2], 2'b00};
                    id_valid_d = 1'b0;
                end else if (load) begin
                    id_valid_d  = 1'b1;
                    id_pc_d     = pc_q;
                    id_instr_d  = fetch_instr;
                    id_pre_pc_d = fetch_pre_pc;
                    id_ci_d     = fetch_commit_info;
                    pc_d        = fetch_pre_pc;
                    cnt_d       = cnt_q + WIDTH'(1);
                end
                if (halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // Frozen; only a pending entry may drain.
                if (id_valid_q && id_ready) begin
                    id_valid_d = 1'b0;
                end
            end
            default: begin
                // BOOT (and the unused encoding): one idle cycle.
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                state_d = ST_RUN;
            end
        endcase
    end

    // State and pipeline register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_instr_q  <= '0;
            id_pre_pc_q <= '0;
            id_ci_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
            id_pre_pc_q <= id_pre_pc_d;
            id_ci_q     <= id_ci_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fetch_pc       = pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_instr       = id_instr_q;
    assign id_pre_pc      = id_pre_pc_q;
    assign id_commit_info = id_ci_q;
    assign ctrl_state     = state_q;
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized run against a
// cycle-level behavioural model of the fetch controller.
module tb_fetch_ctrl;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  fetch_pc;
    logic [31:0]  fetch_instr;
    logic [63:0]  fetch_pre_pc;
    logic [160:0] fetch_commit_info;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic         halt;
    logic         id_ready;
    logic         id_valid;
    logic [63:0]  id_pc;
    logic [31:0]  id_instr;
    logic [63:0]  id_pre_pc;
    logic [160:0] id_commit_info;
    logic [1:0]   ctrl_state;
    logic [63:0]  fetch_count;

    int checks = 0;
    int failures = 0;

    // model state
    logic [63:0]  m_pc;
    logic [1:0]   m_st;
    logic         m_valid;
    logic [63:0]  m_ipc;
    logic [31:0]  m_iin;
    logic [63:0]  m_ipre;
    logic [160:0] m_ici;
    logic [63:0]  m_cnt;

    fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_pc          (fetch_pc),
        .fetch_instr       (fetch_instr),
        .fetch_pre_pc      (fetch_pre_pc),
        .fetch_commit_info (fetch_commit_info),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .halt              (halt),
        .id_ready          (id_ready),
        .id_valid          (id_valid),
        .id_pc             (id_pc),
        .id_instr          (id_instr),
        .id_pre_pc         (id_pre_pc),
        .id_commit_info    (id_commit_info),
        .ctrl_state        (ctrl_state),
        .fetch_count       (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Behavioural fetch stage feeding the DUT.
    assign fetch_instr       = instr_of(fetch_pc);
    assign fetch_pre_pc      = fetch_pc + 64'd4;
    assign fetch_commit_info = {1'b1, instr_of(fetch_pc),
                                fetch_pc + 64'd4, fetch_pc};

    task automatic model_step();
        if (rst) begin
            m_pc = RPC; m_st = 2'd0; m_valid = 1'b0;
            m_ipc = '0; m_iin = '0; m_ipre = '0; m_ici = '0; m_cnt = '0;
        end else if (m_st == 2'd1) begin
            if (redirect_valid) begin
                m_pc = redirect_pc & ~64'd3;
                m_valid = 1'b0;
            end else if (!m_valid || id_ready) begin
                m_ipc = m_pc;
                m_iin = instr_of(m_pc);
                m_ipre = m_pc + 64'd4;
                m_ici = {1'b1, m_iin, m_ipre, m_pc};
                m_valid = 1'b1;
                m_pc = m_pc + 64'd4;
                m_cnt = m_cnt + 64'd1;
            end
            if (halt) m_st = 2'd2;
        end else if (m_st == 2'd2) begin
            if (id_ready) m_valid = 1'b0;
        end else begin
            if (redirect_valid) m_pc = redirect_pc;
            m_st = 2'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; id_ready = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        checks++;
        if ({ctrl_state, id_valid, fetch_pc, fetch_count} !==
            {2'd0, 1'b0, RPC, 64'd0}) begin
            failures++;
            $display("FAIL reset_ctrl: st=%0d v=%b pc=%h cnt=%0d want 0 0 %h 0",
                     ctrl_state, id_valid, fetch_pc, fetch_count, RPC);
        end
        checks++;
        if ({id_pc, id_instr, id_pre_pc, id_commit_info} !== '0) begin
            failures++;
            $display("FAIL reset_data: id_pc=%h instr=%h pre=%h want 0",
                     id_pc, id_instr, id_pre_pc);
        end
    endtask

    task automatic test_boot_seq();
        rst = 1'b0; id_ready = 1'b1;
        tick();
        checks++;
        if ({ctrl_state, id_valid, fetch_pc} !== {2'd1, 1'b0, RPC}) begin
            failures++;
            $display("FAIL boot_cycle1: st=%0d v=%b pc=%h want 1 0 %h",
                     ctrl_state, id_valid, fetch_pc, RPC);
        end
        tick();
        checks++;
        if ({id_valid, id_pc, fetch_pc, fetch_count, id_instr, id_pre_pc} !==
            {1'b1, RPC, RPC + 64'd4, 64'd1, instr_of(RPC), RPC + 64'd4}) begin
            failures++;
            $display("FAIL boot_cycle2: v=%b id_pc=%h pc=%h cnt=%0d instr=%h",
                     id_valid, id_pc, fetch_pc, fetch_count, id_instr);
        end
        tick();
        checks++;
        if ({id_pc, fetch_count} !== {RPC + 64'd4, 64'd2}) begin
            failures++;
            $display("FAIL boot_cycle3: id_pc=%h cnt=%0d want %h 2",
                     id_pc, fetch_count, RPC + 64'd4);
        end
    endtask

    task automatic test_stall();
        tick();
        checks++;
        if (id_pc !== 64'h8000_0008) begin
            failures++;
            $display("FAIL stall_pre: id_pc=%h want 80000008", id_pc);
        end
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({id_valid, id_pc, id_instr, fetch_pc} !==
                {1'b1, 64'h8000_0008, instr_of(64'h8000_0008),
                 64'h8000_000C}) begin
                failures++;
                $display("FAIL stall_hold: v=%b id_pc=%h pc=%h",
                         id_valid, id_pc, fetch_pc);
            end
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if ({id_pc, fetch_count} !== {64'h8000_000C, 64'd4}) begin
            failures++;
            $display("FAIL stall_release: id_pc=%h cnt=%0d want 8000000c 4",
                     id_pc, fetch_count);
        end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1003;
        tick();
        checks++;
        if ({id_valid, fetch_pc, fetch_count} !==
            {1'b0, 64'h8000_1000, 64'd4}) begin
            failures++;
            $display("FAIL redirect_flush: v=%b pc=%h cnt=%0d want 0 80001000 4",
                     id_valid, fetch_pc, fetch_count);
        end
        redirect_valid = 1'b0;
        tick();
        checks++;
        if ({id_valid, id_pc, fetch_count} !==
            {1'b1, 64'h8000_1000, 64'd5}) begin
            failures++;
            $display("FAIL redirect_target: v=%b id_pc=%h cnt=%0d",
                     id_valid, id_pc, fetch_count);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if ({ctrl_state, id_valid, id_pc, fetch_pc} !==
            {2'd2, 1'b1, 64'h8000_1000, 64'h8000_1004}) begin
            failures++;
            $display("FAIL halt_enter: st=%0d v=%b id_pc=%h pc=%h",
                     ctrl_state, id_valid, id_pc, fetch_pc);
        end
        tick();
        checks++;
        if ({id_valid, id_pc} !== {1'b1, 64'h8000_1000}) begin
            failures++;
            $display("FAIL halt_hold: v=%b id_pc=%h", id_valid, id_pc);
        end
        id_ready = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_5000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ctrl_state, id_valid, fetch_pc, fetch_count} !==
                {2'd2, 1'b0, 64'h8000_1004, 64'd5}) begin
                failures++;
                $display("FAIL halt_frozen: st=%0d v=%b pc=%h cnt=%0d",
                         ctrl_state, id_valid, fetch_pc, fetch_count);
            end
        end
        redirect_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ctrl_state, id_valid, fetch_pc, fetch_count, id_pc} !==
            {2'd0, 1'b0, RPC, 64'd0, 64'd0}) begin
            failures++;
            $display("FAIL halt_reset: st=%0d v=%b pc=%h cnt=%0d",
                     ctrl_state, id_valid, fetch_pc, fetch_count);
        end
    endtask

    task automatic test_halt_redirect();
        id_ready = 1'b1;
        tick(); tick(); tick();
        halt = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        tick();
        halt = 1'b0; redirect_valid = 1'b0;
        checks++;
        if ({ctrl_state, id_valid, fetch_pc} !==
            {2'd2, 1'b0, 64'h8000_2000}) begin
            failures++;
            $display("FAIL halt_redirect: st=%0d v=%b pc=%h",
                     ctrl_state, id_valid, fetch_pc);
        end
        tick();
        checks++;
        if ({id_valid, fetch_pc, fetch_count} !==
            {1'b0, 64'h8000_2000, 64'd2}) begin
            failures++;
            $display("FAIL halt_redirect_noload: v=%b pc=%h cnt=%0d",
                     id_valid, fetch_pc, fetch_count);
        end
    endtask

    task automatic test_reset_in_stall();
        rst = 1'b1;
        tick();
        rst = 1'b0; id_ready = 1'b1;
        tick(); tick(); tick();
        id_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; id_ready = 1'b1;
        checks++;
        if ({ctrl_state, id_valid, fetch_pc, fetch_count, id_pc} !==
            {2'd0, 1'b0, RPC, 64'd0, 64'd0}) begin
            failures++;
            $display("FAIL stall_reset: st=%0d v=%b pc=%h cnt=%0d",
                     ctrl_state, id_valid, fetch_pc, fetch_count);
        end
        tick(); tick();
        checks++;
        if ({id_valid, id_pc, fetch_count} !== {1'b1, RPC, 64'd1}) begin
            failures++;
            $display("FAIL stall_reboot: v=%b id_pc=%h cnt=%0d",
                     id_valid, id_pc, fetch_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom % 60) == 0;
            id_ready       = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 10) == 0;
            redirect_pc    = {$urandom, $urandom};
            halt           = ($urandom % 50) == 0;
            tick();
            checks++;
            if ({ctrl_state, id_valid, fetch_pc, fetch_count, id_pc,
                 id_instr, id_pre_pc, id_commit_info} !==
                {m_st, m_valid, m_pc, m_cnt, m_ipc, m_iin, m_ipre, m_ici}) begin
                failures++;
                $display("FAIL random[%0d]: st=%0d/%0d v=%b/%b pc=%h/%h cnt=%0d/%0d id_pc=%h/%h",
                         i, ctrl_state, m_st, id_valid, m_valid, fetch_pc,
                         m_pc, fetch_count, m_cnt, id_pc, m_ipc);
            end
        end
        rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; id_ready = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_boot_seq();
        test_stall();
        test_redirect();
        test_halt();
        test_halt_redirect();
        test_reset_in_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
